// File: rtl/word32_to16_sequencer.sv
// Narrows 32-bit words to 16-bit beats: truncated upper half, rounded/saturated
// upper half, or both halves in either order, with valid/ready on both sides.
module word32_to16_sequencer #(
    parameter int         CNT_W    = 16,
    parameter logic [1:0] DEF_MODE = 2'b00
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [31:0]      IN_DATA,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [1:0]       MODE,
    output logic [15:0]      OUT_DATA,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic             OUT_LAST,
    output logic [CNT_W-1:0] WORD_CNT,
    input  logic             CNT_CLR,
    output logic             BUSY
);

    localparam logic [1:0] ST_EMPTY = 2'b00;
    localparam logic [1:0] ST_BEAT0 = 2'b01;
    localparam logic [1:0] ST_BEAT1 = 2'b10;

    localparam logic [1:0] MODE_TRUNC = 2'b00;
    localparam logic [1:0] MODE_HIGH1 = 2'b01;
    localparam logic [1:0] MODE_LOW1  = 2'b10;
    localparam logic [1:0] MODE_ROUND = 2'b11;

    logic [1:0]       state_q, state_d;
    logic [31:0]      hold_q, hold_d;
    logic [1:0]       mode_q, mode_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic        single_s;
    logic        last_s;
    logic        accept_s;
    logic        out_fire_s;
    logic [16:0] round_sum_s;
    logic [15:0] rounded_s;

    assign single_s   = (mode_q == MODE_TRUNC) || (mode_q == MODE_ROUND);
    assign last_s     = (state_q == ST_BEAT1) || ((state_q == ST_BEAT0) && single_s);
    assign OUT_VALID  = (state_q != ST_EMPTY);
    assign OUT_LAST   = OUT_VALID && last_s;
    assign BUSY       = OUT_VALID;
    // Ready depends only on registered state and OUT_READY, never on IN_VALID.
    assign IN_READY   = (state_q == ST_EMPTY) || (OUT_READY && OUT_VALID && last_s);
    assign accept_s   = IN_VALID && IN_READY;
    assign out_fire_s = OUT_VALID && OUT_READY;
    assign WORD_CNT   = cnt_q;

    // A carry out of the 17-bit sum only happens for 16'hFFFF + 1, which saturates.
    assign round_sum_s = {1'b0, hold_q[31:16]} + {16'h0000, hold_q[15]};
    assign rounded_s   = round_sum_s[16] ? 16'hFFFF : round_sum_s[15:0];

    // Output beat selection from registered hold/mode/state.
    always_comb begin
        OUT_DATA = hold_q[31:16];
        case (mode_q)
            MODE_TRUNC: OUT_DATA = hold_q[31:16];
            MODE_HIGH1: OUT_DATA = (state_q == ST_BEAT1) ? hold_q[15:0] : hold_q[31:16];
            MODE_LOW1:  OUT_DATA = (state_q == ST_BEAT1) ? hold_q[31:16] : hold_q[15:0];
            MODE_ROUND: OUT_DATA = rounded_s;
            default:    OUT_DATA = hold_q[31:16];
        endcase
    end

    // Next-state logic: a new word takes priority over retiring the current one.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        mode_d  = mode_q;
        if (accept_s) begin
            hold_d  = IN_DATA;
            mode_d  = MODE;
            state_d = ST_BEAT0;
        end else if (out_fire_s && last_s) begin
            state_d = ST_EMPTY;
        end else if (out_fire_s && (state_q == ST_BEAT0) && !single_s) begin
            state_d = ST_BEAT1;
        end else begin
            state_d = state_q;
        end
    end

    // Completed-word counter; clear wins over a same-cycle increment.
    always_comb begin
        cnt_d = cnt_q;
        if (CNT_CLR) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (out_fire_s && last_s) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= ST_EMPTY;
            hold_q  <= 32'h0000_0000;
            mode_q  <= DEF_MODE;
            cnt_q   <= {CNT_W{1'b0}};
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_word32_to16_sequencer.sv
// Directed self-checking bench for word32_to16_sequencer.
module tb_word32_to16_sequencer;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic [31:0] IN_DATA;
    logic        IN_VALID;
    logic        IN_READY;
    logic [1:0]  MODE;
    logic [15:0] OUT_DATA;
    logic        OUT_VALID;
    logic        OUT_READY;
    logic        OUT_LAST;
    logic [15:0] WORD_CNT;
    logic        CNT_CLR;
    logic        BUSY;

    int checks_r = 0;
    int errors_r = 0;

    word32_to16_sequencer #(.CNT_W(16), .DEF_MODE(2'b00)) dut (
        .CLK(CLK), .RST_N(RST_N), .IN_DATA(IN_DATA), .IN_VALID(IN_VALID),
        .IN_READY(IN_READY), .MODE(MODE), .OUT_DATA(OUT_DATA),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_LAST(OUT_LAST),
        .WORD_CNT(WORD_CNT), .CNT_CLR(CNT_CLR), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_r++;
        if (obs !== exp) begin
            errors_r++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs then change and outputs settle.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RST_N = 1'b0; IN_DATA = 32'h1234_5678; IN_VALID = 1'b1;
        MODE = 2'b00; OUT_READY = 1'b1; CNT_CLR = 1'b0;
        repeat (3) tick();
        #1;
        check_val("rst_out_valid", {31'd0, OUT_VALID}, 32'd0);
        check_val("rst_in_ready", {31'd0, IN_READY}, 32'd1);
        check_val("rst_cnt", {16'd0, WORD_CNT}, 32'd0);
        check_val("rst_out_data", {16'd0, OUT_DATA}, 32'd0);
        check_val("rst_busy", {31'd0, BUSY}, 32'd0);
        check_val("rst_last", {31'd0, OUT_LAST}, 32'd0);
        IN_VALID = 1'b0; RST_N = 1'b1;
        tick();
        check_val("no_accept_in_rst", {31'd0, OUT_VALID}, 32'd0);

        // Truncate streaming, one word per cycle
        MODE = 2'b00; IN_VALID = 1'b1; IN_DATA = 32'h1234_5678;
        tick();
        IN_DATA = 32'hABCD_0001; #1;
        check_val("trunc0", {16'd0, OUT_DATA}, 32'h1234);
        check_val("trunc0_last", {31'd0, OUT_LAST}, 32'd1);
        check_val("trunc0_rdy", {31'd0, IN_READY}, 32'd1);
        tick();
        IN_DATA = 32'h0000_FFFF; #1;
        check_val("trunc1", {16'd0, OUT_DATA}, 32'hABCD);
        check_val("trunc1_last", {31'd0, OUT_LAST}, 32'd1);
        tick();
        IN_VALID = 1'b0; #1;
        check_val("trunc2", {16'd0, OUT_DATA}, 32'h0000);
        check_val("trunc2_last", {31'd0, OUT_LAST}, 32'd1);
        tick();
        check_val("trunc_idle", {31'd0, OUT_VALID}, 32'd0);
        check_val("trunc_cnt", {16'd0, WORD_CNT}, 32'd3);

        // Two-beat, high half first then low half first
        MODE = 2'b01; IN_VALID = 1'b1; IN_DATA = 32'hDEAD_BEEF;
        tick();
        IN_VALID = 1'b0; #1;
        check_val("hf_b0", {16'd0, OUT_DATA}, 32'hDEAD);
        check_val("hf_b0_last", {31'd0, OUT_LAST}, 32'd0);
        check_val("hf_b0_rdy", {31'd0, IN_READY}, 32'd0);
        tick();
        check_val("hf_b1", {16'd0, OUT_DATA}, 32'hBEEF);
        check_val("hf_b1_last", {31'd0, OUT_LAST}, 32'd1);
        check_val("hf_b1_rdy", {31'd0, IN_READY}, 32'd1);
        tick();
        MODE = 2'b10; IN_VALID = 1'b1;
        tick();
        IN_VALID = 1'b0; #1;
        check_val("lf_b0", {16'd0, OUT_DATA}, 32'hBEEF);
        check_val("lf_b0_last", {31'd0, OUT_LAST}, 32'd0);
        tick();
        check_val("lf_b1", {16'd0, OUT_DATA}, 32'hDEAD);
        check_val("lf_b1_last", {31'd0, OUT_LAST}, 32'd1);
        tick();
        check_val("two_beat_cnt", {16'd0, WORD_CNT}, 32'd5);

        // Rounding and saturation
        MODE = 2'b11; IN_VALID = 1'b1; IN_DATA = 32'h0001_7FFF;
        tick();
        IN_DATA = 32'h0001_8000; #1;
        check_val("rnd_down", {16'd0, OUT_DATA}, 32'h0001);
        tick();
        IN_DATA = 32'hFFFF_8000; #1;
        check_val("rnd_up", {16'd0, OUT_DATA}, 32'h0002);
        tick();
        IN_VALID = 1'b0; #1;
        check_val("rnd_sat", {16'd0, OUT_DATA}, 32'hFFFF);
        tick();
        check_val("rnd_cnt", {16'd0, WORD_CNT}, 32'd8);

        // Backpressure with MODE changing mid-word
        OUT_READY = 1'b0; MODE = 2'b01; IN_VALID = 1'b1; IN_DATA = 32'h1111_2222;
        tick();
        IN_VALID = 1'b0; MODE = 2'b00;
        for (int i = 0; i < 5; i++) begin
            #1;
            check_val("bp_hold", {16'd0, OUT_DATA}, 32'h1111);
            check_val("bp_rdy", {31'd0, IN_READY}, 32'd0);
            check_val("bp_valid", {31'd0, OUT_VALID}, 32'd1);
            tick();
        end
        OUT_READY = 1'b1; #1;
        check_val("bp_b0", {16'd0, OUT_DATA}, 32'h1111);
        check_val("bp_b0_last", {31'd0, OUT_LAST}, 32'd0);
        tick();
        IN_VALID = 1'b1; IN_DATA = 32'hCAFE_0000; MODE = 2'b00; #1;
        check_val("bp_b1", {16'd0, OUT_DATA}, 32'h2222);
        check_val("bp_b1_rdy", {31'd0, IN_READY}, 32'd1);
        tick();
        IN_VALID = 1'b0; #1;
        check_val("no_bubble_valid", {31'd0, OUT_VALID}, 32'd1);
        check_val("no_bubble_data", {16'd0, OUT_DATA}, 32'hCAFE);
        tick();
        check_val("bp_cnt", {16'd0, WORD_CNT}, 32'd10);

        // Counter wrap after 2^16-1 completed words
        CNT_CLR = 1'b1;
        tick();
        CNT_CLR = 1'b0; #1;
        check_val("clr_cnt", {16'd0, WORD_CNT}, 32'd0);
        MODE = 2'b00; IN_VALID = 1'b1; IN_DATA = 32'h0101_0202;
        repeat (65536) tick();
        IN_VALID = 1'b0; #1;
        check_val("preload_cnt", {16'd0, WORD_CNT}, 32'hFFFF);
        check_val("preload_valid", {31'd0, OUT_VALID}, 32'd1);
        tick();
        check_val("wrap_cnt", {16'd0, WORD_CNT}, 32'd0);

        // Clear coincident with a last beat
        IN_VALID = 1'b1; IN_DATA = 32'h5555_0000;
        tick();
        IN_VALID = 1'b0;
        tick();
        check_val("pre_clr_cnt", {16'd0, WORD_CNT}, 32'd1);
        IN_VALID = 1'b1;
        tick();
        IN_VALID = 1'b0; CNT_CLR = 1'b1; #1;
        check_val("clr_last", {31'd0, OUT_LAST}, 32'd1);
        tick();
        CNT_CLR = 1'b0; #1;
        check_val("clr_wins", {16'd0, WORD_CNT}, 32'd0);

        // Reset during BEAT1
        MODE = 2'b01; IN_VALID = 1'b1; IN_DATA = 32'hAAAA_5555;
        tick();
        IN_VALID = 1'b0;
        tick();
        check_val("mid_b1", {16'd0, OUT_DATA}, 32'h5555);
        RST_N = 1'b0;
        tick();
        RST_N = 1'b1; #1;
        check_val("mid_rst_valid", {31'd0, OUT_VALID}, 32'd0);
        check_val("mid_rst_busy", {31'd0, BUSY}, 32'd0);
        check_val("mid_rst_cnt", {16'd0, WORD_CNT}, 32'd0);
        check_val("mid_rst_rdy", {31'd0, IN_READY}, 32'd1);
        check_val("mid_rst_data", {16'd0, OUT_DATA}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks_r, errors_r);
        $finish;
    end

endmodule
